tt_sweep_ctrl: RTL

TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

---
 rtl/tt_sweep_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: walks x through 0..15, samples y0 per vector, compares with an expected table.
// Optional feature: define TT_SWEEP_NEG_EN to add neg_mask and drive x = index ^ captured mask.
module tt_sweep_ctrl #(
  parameter int unsigned SETTLE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expect_tt,
`ifdef TT_SWEEP_NEG_EN
  input  logic [3:0]  neg_mask,
`endif
  output logic [3:0]  x,
  input  logic        y0,
  output logic        busy,
  output logic [15:0] tt,
  output logic        match,
  output logic        tt_valid,
  input  logic        tt_ready
);

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [3:0]  r_cnt;
  logic [15:0] r_exp;
  logic [3:0]  r_mask;
  logic [3:0]  r_x;
  logic [15:0] r_tt;
  logic        r_match;
  logic        r_valid;
  logic        r_busy;
  logic [3:0]  w_mask;
  logic        w_last;

`ifdef TT_SWEEP_NEG_EN
  assign w_mask = neg_mask;
`else
  assign w_mask = 4'h0;
`endif

  // Last hold cycle of the current vector: the only cycle allowed to write tt.
  assign w_last = (r_cnt == LP_SETTLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 4'h0;
      r_cnt   <= 4'h0;
      r_exp   <= 16'h0;
      r_mask  <= 4'h0;
      r_x     <= 4'h0;
      r_tt    <= 16'h0;
      r_match <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_exp   <= expect_tt;
            r_mask  <= w_mask;
            r_idx   <= 4'h0;
            r_cnt   <= 4'h0;
            r_tt    <= 16'h0;
            r_match <= 1'b0;
            r_x     <= w_mask;
            r_busy  <= 1'b1;
            r_state <= S_SWEEP;
          end
        end
        S_SWEEP: begin
          if (abort) begin
            r_x     <= 4'h0;
            r_idx   <= 4'h0;
            r_cnt   <= 4'h0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_last) begin
            r_tt[r_idx] <= y0;
            r_cnt       <= 4'h0;
            if (r_idx == 4'hF) begin
              r_x     <= 4'h0;
              r_state <= S_HOLD;
            end else begin
              r_idx <= r_idx + 4'd1;
              r_x   <= (r_idx + 4'd1) ^ r_mask;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_HOLD: begin
          // First HOLD cycle publishes the result; later cycles wait for the consumer.
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_match <= (r_tt == r_exp);
          end else if (tt_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_x     <= 4'h0;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign x        = r_x;
  assign busy     = r_busy;
  assign tt       = r_tt;
  assign match    = r_match;
  assign tt_valid = r_valid;

endmodule
